// File: rtl/dpram_pkg.sv
// Shared constants and helpers for the byte-lane dual-port RAM.
package dpram_pkg;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int unsigned MAX_DATA = 512;

  typedef logic [MAX_DATA-1:0] word_t;

  function automatic int unsigned lanes(input int unsigned data, input int unsigned lane);
    return data / lane;
  endfunction

  // Take new_word bits on lanes whose write enable is set, old_word elsewhere.
  function automatic word_t merge_word(input word_t old_word, input word_t new_word,
                                       input word_t we, input int unsigned lane);
    word_t merged;
    merged = old_word;
    for (int unsigned i = 0; i < MAX_DATA; i++) begin
      if (we[i / lane]) merged[i] = new_word[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dpram_be_outreg.sv
// Optional output register stage carrying read data, valid and a pulse flag.
module dpram_be_outreg #(
  parameter int unsigned W     = 16,
  parameter int unsigned STAGE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pre_data,
  input  logic         pre_valid,
  input  logic         pre_flag,
  output logic [W-1:0] post_data,
  output logic         post_valid,
  output logic         post_flag
);

  logic [W-1:0] data_q;
  logic         valid_q;
  logic         flag_q;

  // Data only advances on a valid result so the port output holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      valid_q <= pre_valid;
      flag_q  <= pre_flag;
      if (pre_valid) data_q <= pre_data;
    end
  end

  assign post_data  = (STAGE != 0) ? data_q  : pre_data;
  assign post_valid = (STAGE != 0) ? valid_q : pre_valid;
  assign post_flag  = (STAGE != 0) ? flag_q  : pre_flag;

endmodule

// File: rtl/dpram_be.sv
// True dual-port RAM with byte-lane writes, read-during-write mode and collision flag.
module dpram_be
  import dpram_pkg::*;
#(
  parameter int unsigned DATA     = 16,
  parameter int unsigned ADDR     = 5,
  parameter int unsigned LANE     = 8,
  parameter int unsigned RDW_MODE = RDW_READ_FIRST,
  parameter int unsigned OUT_REG  = 0,
  localparam int unsigned LANES   = lanes(DATA, LANE)
) (
  input  logic              clK,
  input  logic              rst,
  input  logic              a_port_EN,
  input  logic [LANES-1:0]  a_port_WR,
  input  logic [ADDR-1:0]   a_port_ADDR,
  input  logic [DATA-1:0]   a_port_data_IN,
  output logic [DATA-1:0]   a_port_data_OUT,
  output logic              a_port_VALID,
  input  logic              b_port_EN,
  input  logic [LANES-1:0]  b_port_WR,
  input  logic [ADDR-1:0]   b_port_ADDR,
  input  logic [DATA-1:0]   b_port_data_IN,
  output logic [DATA-1:0]   b_port_data_OUT,
  output logic              b_port_VALID,
  output logic              collision
);

  localparam int unsigned DEPTH = 2 ** ADDR;

  if (LANE == 0 || (DATA % LANE) != 0) begin : g_bad_lane
    $error("dpram_be: DATA must be a nonzero multiple of LANE");
  end
  if (OUT_REG > 1) begin : g_bad_outreg
    $error("dpram_be: OUT_REG must be 0 or 1");
  end
  if (RDW_MODE > 1) begin : g_bad_rdw
    $error("dpram_be: RDW_MODE must be 0 or 1");
  end
  if (DATA > MAX_DATA) begin : g_bad_width
    $error("dpram_be: DATA exceeds MAX_DATA");
  end

  logic [DATA-1:0]  mem [DEPTH];
  logic [LANES-1:0] a_we, b_we;
  logic             same_addr;
  logic [DATA-1:0]  a_old, b_old, a_new, b_new, a_rd, b_rd;

  logic [DATA-1:0]  a_d1, b_d1;
  logic             a_v1, b_v1, coll1;
  logic             b_flag_unused;

  // a_new/b_new are the words after both writes of this edge, B applied last.
  always_comb begin
    a_we      = (a_port_EN && !rst) ? a_port_WR : '0;
    b_we      = (b_port_EN && !rst) ? b_port_WR : '0;
    same_addr = (a_port_ADDR == b_port_ADDR);
    a_old     = mem[a_port_ADDR];
    b_old     = mem[b_port_ADDR];
    a_new     = DATA'(merge_word(word_t'(a_old), word_t'(a_port_data_IN), word_t'(a_we), LANE));
    if (same_addr) begin
      a_new = DATA'(merge_word(word_t'(a_new), word_t'(b_port_data_IN), word_t'(b_we), LANE));
      b_new = a_new;
    end else begin
      b_new = DATA'(merge_word(word_t'(b_old), word_t'(b_port_data_IN), word_t'(b_we), LANE));
    end
    a_rd = (RDW_MODE == RDW_WRITE_FIRST) ? a_new : a_old;
    b_rd = (RDW_MODE == RDW_WRITE_FIRST) ? b_new : b_old;
  end

  always_ff @(posedge clK) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (a_we[i]) mem[a_port_ADDR][i*LANE +: LANE] <= a_port_data_IN[i*LANE +: LANE];
      if (b_we[i]) mem[b_port_ADDR][i*LANE +: LANE] <= b_port_data_IN[i*LANE +: LANE];
    end
  end

  always_ff @(posedge clK) begin
    if (rst) begin
      a_d1  <= '0;
      b_d1  <= '0;
      a_v1  <= 1'b0;
      b_v1  <= 1'b0;
      coll1 <= 1'b0;
    end else begin
      a_v1  <= a_port_EN;
      b_v1  <= b_port_EN;
      coll1 <= a_port_EN && b_port_EN && same_addr && ((|a_port_WR) || (|b_port_WR));
      if (a_port_EN) a_d1 <= a_rd;
      if (b_port_EN) b_d1 <= b_rd;
    end
  end

  // Collision rides in port A's stage so it stays aligned with both VALIDs.
  dpram_be_outreg #(.W(DATA), .STAGE(OUT_REG)) u_out_a (
    .clk        (clK),
    .rst        (rst),
    .pre_data   (a_d1),
    .pre_valid  (a_v1),
    .pre_flag   (coll1),
    .post_data  (a_port_data_OUT),
    .post_valid (a_port_VALID),
    .post_flag  (collision)
  );

  dpram_be_outreg #(.W(DATA), .STAGE(OUT_REG)) u_out_b (
    .clk        (clK),
    .rst        (rst),
    .pre_data   (b_d1),
    .pre_valid  (b_v1),
    .pre_flag   (1'b0),
    .post_data  (b_port_data_OUT),
    .post_valid (b_port_VALID),
    .post_flag  (b_flag_unused)
  );

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: read-first/latency-1 and write-first/latency-2 instances side by side.
module tb_dpram_be;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_en, b_en;
  logic [1:0]  a_wr, b_wr;
  logic [4:0]  a_addr, b_addr;
  logic [15:0] a_din, b_din;

  logic [15:0] a_q [2];
  logic [15:0] b_q [2];
  logic        a_v [2];
  logic        b_v [2];
  logic        coll [2];

  dpram_be #(.DATA(16), .ADDR(5), .LANE(8), .RDW_MODE(0), .OUT_REG(0)) dut0 (
    .clK(clk), .rst(rst),
    .a_port_EN(a_en), .a_port_WR(a_wr), .a_port_ADDR(a_addr), .a_port_data_IN(a_din),
    .a_port_data_OUT(a_q[0]), .a_port_VALID(a_v[0]),
    .b_port_EN(b_en), .b_port_WR(b_wr), .b_port_ADDR(b_addr), .b_port_data_IN(b_din),
    .b_port_data_OUT(b_q[0]), .b_port_VALID(b_v[0]),
    .collision(coll[0])
  );

  dpram_be #(.DATA(16), .ADDR(5), .LANE(8), .RDW_MODE(1), .OUT_REG(1)) dut1 (
    .clK(clk), .rst(rst),
    .a_port_EN(a_en), .a_port_WR(a_wr), .a_port_ADDR(a_addr), .a_port_data_IN(a_din),
    .a_port_data_OUT(a_q[1]), .a_port_VALID(a_v[1]),
    .b_port_EN(b_en), .b_port_WR(b_wr), .b_port_ADDR(b_addr), .b_port_data_IN(b_din),
    .b_port_data_OUT(b_q[1]), .b_port_VALID(b_v[1]),
    .collision(coll[1])
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: memory array plus a per-edge log of what each access would return.
  typedef struct {
    logic        rst, a_en, b_en, coll;
    logic [15:0] a_old, a_new, b_old, b_new;
  } hist_t;

  logic [15:0] m [DEPTH];
  hist_t       hist [0:4095];
  int          cyc = 0;
  logic [15:0] ea [2];
  logic [15:0] eb [2];
  logic        eav [2];
  logic        ebv [2];
  logic        ec [2];

  task automatic tick();
    hist_t       h;
    logic [15:0] nm [DEPTH];
    int          e;
    logic        disc;
    @(posedge clk);
    nm = m;
    for (int l = 0; l < 2; l++)
      if (!rst && a_en && a_wr[l]) nm[a_addr][l*8 +: 8] = a_din[l*8 +: 8];
    for (int l = 0; l < 2; l++)
      if (!rst && b_en && b_wr[l]) nm[b_addr][l*8 +: 8] = b_din[l*8 +: 8];
    h.rst   = rst;
    h.a_en  = a_en;
    h.b_en  = b_en;
    h.a_old = m[a_addr];
    h.a_new = nm[a_addr];
    h.b_old = m[b_addr];
    h.b_new = nm[b_addr];
    h.coll  = a_en && b_en && (a_addr == b_addr) && ((a_wr | b_wr) != 2'b00);
    if (!rst) m = nm;
    hist[cyc] = h;
    for (int k = 0; k < 2; k++) begin
      e    = cyc - k;
      disc = (e < 0);
      for (int j = (e < 0) ? 0 : e; j <= cyc; j++)
        if (hist[j].rst) disc = 1'b1;
      if (h.rst) begin
        ea[k] = '0;
        eb[k] = '0;
      end
      if (disc) begin
        eav[k] = 1'b0;
        ebv[k] = 1'b0;
        ec[k]  = 1'b0;
      end else begin
        eav[k] = hist[e].a_en;
        ebv[k] = hist[e].b_en;
        ec[k]  = hist[e].coll;
        if (eav[k]) ea[k] = (k == 1) ? hist[e].a_new : hist[e].a_old;
        if (ebv[k]) eb[k] = (k == 1) ? hist[e].b_new : hist[e].b_old;
      end
    end
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d_a_data", k), a_q[k], ea[k]);
      chk($sformatf("dut%0d_b_data", k), b_q[k], eb[k]);
      chk($sformatf("dut%0d_a_valid", k), {15'd0, a_v[k]}, {15'd0, eav[k]});
      chk($sformatf("dut%0d_b_valid", k), {15'd0, b_v[k]}, {15'd0, ebv[k]});
      chk($sformatf("dut%0d_collision", k), {15'd0, coll[k]}, {15'd0, ec[k]});
    end
  endtask

  task automatic idle();
    a_en = 1'b0; b_en = 1'b0; a_wr = 2'b00; b_wr = 2'b00;
  endtask

  task automatic drive(input logic ae, input logic [1:0] aw, input logic [4:0] aa, input logic [15:0] ad,
                       input logic be, input logic [1:0] bw, input logic [4:0] ba, input logic [15:0] bd);
    a_en = ae; a_wr = aw; a_addr = aa; a_din = ad;
    b_en = be; b_wr = bw; b_addr = ba; b_din = bd;
  endtask

  // One cycle of stimulus and the read results each instance must eventually hold.
  typedef struct {
    logic [1:0]  a_wr;
    logic [4:0]  a_addr;
    logic [15:0] a_din;
    logic [1:0]  b_wr;
    logic [4:0]  b_addr;
    logic [15:0] b_din;
    logic [15:0] ea0, eb0, ea1, eb1;
  } row_t;

  function automatic row_t mk(input logic [1:0] aw, input logic [4:0] aa, input logic [15:0] ad,
                              input logic [1:0] bw, input logic [4:0] ba, input logic [15:0] bd,
                              input logic [15:0] ea0, input logic [15:0] eb0,
                              input logic [15:0] ea1, input logic [15:0] eb1);
    row_t r;
    r.a_wr = aw; r.a_addr = aa; r.a_din = ad;
    r.b_wr = bw; r.b_addr = ba; r.b_din = bd;
    r.ea0 = ea0; r.eb0 = eb0; r.ea1 = ea1; r.eb1 = eb1;
    return r;
  endfunction

  initial begin
    row_t rows [13];
    rows[0]  = mk(2'b11, 5'd3,  16'hBEEF, 2'b00, 5'd3,  16'h0000, 16'h0303, 16'h0303, 16'hBEEF, 16'hBEEF);
    rows[1]  = mk(2'b00, 5'd3,  16'h0000, 2'b00, 5'd4,  16'h0000, 16'hBEEF, 16'h0404, 16'hBEEF, 16'h0404);
    rows[2]  = mk(2'b11, 5'd7,  16'h1234, 2'b00, 5'd0,  16'h0000, 16'h0707, 16'h0000, 16'h1234, 16'h0000);
    rows[3]  = mk(2'b10, 5'd7,  16'hAB00, 2'b00, 5'd7,  16'h0000, 16'h1234, 16'h1234, 16'hAB34, 16'hAB34);
    rows[4]  = mk(2'b00, 5'd7,  16'h0000, 2'b00, 5'd7,  16'h0000, 16'hAB34, 16'hAB34, 16'hAB34, 16'hAB34);
    rows[5]  = mk(2'b11, 5'd5,  16'h1111, 2'b00, 5'd6,  16'h0000, 16'h0505, 16'h0606, 16'h1111, 16'h0606);
    rows[6]  = mk(2'b11, 5'd5,  16'h2222, 2'b00, 5'd5,  16'h0000, 16'h1111, 16'h1111, 16'h2222, 16'h2222);
    rows[7]  = mk(2'b11, 5'd9,  16'hAAAA, 2'b10, 5'd9,  16'hBB00, 16'h0909, 16'h0909, 16'hBBAA, 16'hBBAA);
    rows[8]  = mk(2'b00, 5'd9,  16'h0000, 2'b00, 5'd9,  16'h0000, 16'hBBAA, 16'hBBAA, 16'hBBAA, 16'hBBAA);
    rows[9]  = mk(2'b11, 5'd31, 16'h0F0F, 2'b00, 5'd30, 16'h0000, 16'h1F1F, 16'h1E1E, 16'h0F0F, 16'h1E1E);
    rows[10] = mk(2'b00, 5'd31, 16'h0000, 2'b00, 5'd31, 16'h0000, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F);
    rows[11] = mk(2'b01, 5'd9,  16'h0033, 2'b01, 5'd9,  16'h0044, 16'hBBAA, 16'hBBAA, 16'hBB44, 16'hBB44);
    rows[12] = mk(2'b00, 5'd9,  16'h0000, 2'b00, 5'd31, 16'h0000, 16'hBB44, 16'h0F0F, 16'hBB44, 16'h0F0F);

    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    for (int k = 0; k < 2; k++) begin
      ea[k] = '0; eb[k] = '0; eav[k] = 1'b0; ebv[k] = 1'b0; ec[k] = 1'b0;
    end
    rst = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 16'h0, 1'b0, 2'b00, 5'd0, 16'h0);

    // Reset: two cycles, everything zero.
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_dut%0d_a_data", k), a_q[k], 16'h0000);
      chk($sformatf("rst_dut%0d_b_data", k), b_q[k], 16'h0000);
      chk($sformatf("rst_dut%0d_a_valid", k), {15'd0, a_v[k]}, 16'h0000);
      chk($sformatf("rst_dut%0d_collision", k), {15'd0, coll[k]}, 16'h0000);
    end
    rst = 1'b0;

    // Known contents: word i = i * 0x0101.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 2'b11, 5'(i), 16'(i * 257), 1'b0, 2'b00, 5'd0, 16'h0);
      tick();
    end
    idle();
    tick();

    foreach (rows[i]) begin
      drive(1'b1, rows[i].a_wr, rows[i].a_addr, rows[i].a_din,
            1'b1, rows[i].b_wr, rows[i].b_addr, rows[i].b_din);
      tick();
      idle();
      tick();
      tick();
      chk($sformatf("row%0d_dut0_a", i), a_q[0], rows[i].ea0);
      chk($sformatf("row%0d_dut0_b", i), b_q[0], rows[i].eb0);
      chk($sformatf("row%0d_dut1_a", i), a_q[1], rows[i].ea1);
      chk($sformatf("row%0d_dut1_b", i), b_q[1], rows[i].eb1);
    end

    // Latency: single read of @3 (0xBEEF).
    drive(1'b1, 2'b00, 5'd3, 16'h0, 1'b0, 2'b00, 5'd0, 16'h0);
    tick();
    idle();
    chk("lat_e1_dut0_valid", {15'd0, a_v[0]}, 16'h0001);
    chk("lat_e1_dut1_valid", {15'd0, a_v[1]}, 16'h0000);
    chk("lat_e1_dut0_data", a_q[0], 16'hBEEF);
    tick();
    chk("lat_e2_dut0_valid", {15'd0, a_v[0]}, 16'h0000);
    chk("lat_e2_dut1_valid", {15'd0, a_v[1]}, 16'h0001);
    chk("lat_e2_dut1_data", a_q[1], 16'hBEEF);
    tick();

    // Write collision @12: collision pulse aligned with both VALIDs.
    drive(1'b1, 2'b11, 5'd12, 16'hAAAA, 1'b1, 2'b10, 5'd12, 16'hBB00);
    tick();
    idle();
    chk("coll_e1_dut0", {15'd0, coll[0]}, 16'h0001);
    chk("coll_e1_dut0_bvalid", {15'd0, b_v[0]}, 16'h0001);
    chk("coll_e1_dut1", {15'd0, coll[1]}, 16'h0000);
    tick();
    chk("coll_e2_dut0", {15'd0, coll[0]}, 16'h0000);
    chk("coll_e2_dut1", {15'd0, coll[1]}, 16'h0001);
    chk("coll_e2_dut1_avalid", {15'd0, a_v[1]}, 16'h0001);
    chk("coll_e2_dut1_bvalid", {15'd0, b_v[1]}, 16'h0001);
    drive(1'b1, 2'b00, 5'd12, 16'h0, 1'b0, 2'b00, 5'd0, 16'h0);
    tick();
    idle();
    tick();
    chk("coll_mem_dut0", a_q[0], 16'hBBAA);
    chk("coll_mem_dut1", a_q[1], 16'hBBAA);

    // Read then reset next cycle; a write during reset must not land.
    drive(1'b1, 2'b00, 5'd3, 16'h0, 1'b0, 2'b00, 5'd0, 16'h0);
    tick();
    rst = 1'b1;
    drive(1'b1, 2'b11, 5'd3, 16'hDEAD, 1'b0, 2'b00, 5'd0, 16'h0);
    tick();
    chk("midrst_e1_dut1_valid", {15'd0, a_v[1]}, 16'h0000);
    rst = 1'b0;
    idle();
    tick();
    chk("midrst_e2_dut1_valid", {15'd0, a_v[1]}, 16'h0000);
    chk("midrst_e2_dut0_valid", {15'd0, a_v[0]}, 16'h0000);
    drive(1'b1, 2'b00, 5'd3, 16'h0, 1'b0, 2'b00, 5'd0, 16'h0);
    tick();
    idle();
    tick();
    chk("midrst_mem_dut0", a_q[0], 16'hBEEF);
    chk("midrst_mem_dut1", a_q[1], 16'hBEEF);

    // Random traffic, narrow address range to provoke collisions, occasional reset.
    for (int n = 0; n < 500; n++) begin
      rst    = ($urandom_range(0, 49) == 0);
      a_en   = ($urandom_range(0, 3) != 0);
      b_en   = ($urandom_range(0, 3) != 0);
      a_wr   = 2'($urandom);
      b_wr   = 2'($urandom);
      a_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      b_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a_din  = 16'($urandom);
      b_din  = 16'($urandom);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
